// File: rtl/sae_pkg.sv
// Shared constants and types for the sae core arbiter.
// Mode codes, error-flag bit positions and arbiter FSM states.
package sae_pkg;

  localparam logic [1:0] MODE_NOP    = 2'b00;
  localparam logic [1:0] MODE_KEYGEN = 2'b01;
  localparam logic [1:0] MODE_ENC    = 2'b10;
  localparam logic [1:0] MODE_DEC    = 2'b11;

  localparam int ERR_PTXT   = 0;
  localparam int ERR_SECKEY = 1;
  localparam int ERR_CTXT   = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set bit at or above ptr, wrapping.
// Ports: req (request vector), ptr (start index) -> grant (one-hot), idx, any.
module rr_picker #(
  parameter int NUM_REQ = 4,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      idx,
  output logic               any
);

  logic [IW:0]   sum;
  logic [IW-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, ptr} + (IW+1)'(i);
      // ptr and i are both below NUM_REQ, so one subtract wraps
      if (sum >= (IW+1)'(NUM_REQ)) begin
        sum = sum - (IW+1)'(NUM_REQ);
      end
      cand = sum[IW-1:0];
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/sae_arbiter.sv
// Round-robin sequencer sharing one sae core among NUM_REQ requesters.
// Ports: req_* (clients), resp_* (results), busy, sae_* (core side).
// Optional WAIT timeout enabled by defining SAE_ARB_TIMEOUT_EN.
module sae_arbiter
  import sae_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [2*NUM_REQ-1:0] req_mode,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [8*NUM_REQ-1:0] req_key,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   resp_valid,
  output logic [7:0]           resp_data,
  output logic [2:0]           resp_err,
  output logic                 resp_timeout,
  output logic                 busy,
  output logic [1:0]           sae_mode,
  output logic [7:0]           sae_data,
  output logic [7:0]           sae_key,
  output logic                 sae_inputs_valid,
  input  logic [7:0]           sae_data_output,
  input  logic                 sae_output_ready,
  input  logic                 sae_err_ptxt,
  input  logic                 sae_err_seckey,
  input  logic                 sae_err_ctxt
);

  localparam int IW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_param
    $error("sae_arbiter: parameter out of range");
  end

  arb_state_t state_q, state_d;

  logic [IW-1:0]      rr_ptr_q;
  logic [IW-1:0]      owner_q;
  logic [1:0]         mode_q;
  logic [7:0]         data_q;
  logic [7:0]         key_q;
  logic [7:0]         res_data_q;
  logic [2:0]         res_err_q;

  logic [NUM_REQ-1:0] pick_grant;
  logic [IW-1:0]      pick_idx;
  logic               pick_any;

  logic [1:0]         win_mode;
  logic [7:0]         win_data;
  logic [7:0]         win_key;
  logic [2:0]         core_err;
  logic               core_done;
  logic               expire;

  rr_picker #(
    .NUM_REQ(NUM_REQ)
  ) u_pick (
    .req  (req_valid),
    .ptr  (rr_ptr_q),
    .grant(pick_grant),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  always_comb begin
    win_mode = '0;
    win_data = '0;
    win_key  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_grant[i]) begin
        win_mode = req_mode[2*i +: 2];
        win_data = req_data[8*i +: 8];
        win_key  = req_key[8*i +: 8];
      end
    end
  end

  always_comb begin
    core_err             = '0;
    core_err[ERR_PTXT]   = sae_err_ptxt;
    core_err[ERR_SECKEY] = sae_err_seckey;
    core_err[ERR_CTXT]   = sae_err_ctxt;
    core_done            = sae_output_ready | (|core_err);
  end

`ifdef SAE_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] tmo_q;
  logic          res_to_q;

  // tmo_q counts completed WAIT cycles; the last one fires expire
  assign expire = (tmo_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q    <= '0;
      res_to_q <= 1'b0;
    end else begin
      if (state_q == S_ISSUE) begin
        tmo_q <= '0;
      end else if (state_q == S_WAIT) begin
        tmo_q <= tmo_q + CW'(1);
      end
      if (state_q == S_IDLE) begin
        res_to_q <= 1'b0;
      end else if (state_q == S_WAIT && !core_done && expire) begin
        res_to_q <= 1'b1;
      end
    end
  end

  assign resp_timeout = (state_q == S_RESP) ? res_to_q : 1'b0;
`else
  assign expire       = 1'b0;
  assign resp_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (pick_any) begin
          state_d = (win_mode == MODE_NOP) ? S_RESP : S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (core_done || expire) begin
          state_d = S_RESP;
        end
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      mode_q     <= '0;
      data_q     <= '0;
      key_q      <= '0;
      res_data_q <= '0;
      res_err_q  <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (pick_any) begin
            owner_q    <= pick_idx;
            mode_q     <= win_mode;
            data_q     <= win_data;
            key_q      <= win_key;
            res_data_q <= '0;
            res_err_q  <= '0;
          end
        end
        S_WAIT: begin
          if (core_done) begin
            res_data_q <= (|core_err) ? 8'h00 : sae_data_output;
            res_err_q  <= core_err;
          end
        end
        S_RESP: begin
          if (owner_q == IW'(NUM_REQ - 1)) begin
            rr_ptr_q <= '0;
          end else begin
            rr_ptr_q <= owner_q + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  logic core_side;
  assign core_side = (state_q == S_ISSUE) || (state_q == S_WAIT);

  // req_ready is gated by rst_n so it is quiet while reset is held
  assign req_ready = (state_q == S_IDLE && rst_n) ? pick_grant : '0;

  assign busy             = (state_q != S_IDLE);
  assign sae_inputs_valid = (state_q == S_ISSUE);
  assign sae_mode         = core_side ? mode_q : 2'b00;
  assign sae_data         = core_side ? data_q : 8'h00;
  assign sae_key          = core_side ? key_q : 8'h00;

  assign resp_valid = (state_q == S_RESP) ?
                      (NUM_REQ'(1) << owner_q) : '0;
  assign resp_data  = (state_q == S_RESP) ? res_data_q : 8'h00;
  assign resp_err   = (state_q == S_RESP) ? res_err_q : 3'b000;

endmodule
